// File: rtl/delay_line_ctrl.sv
// Circular delay-line sequencer for one single-port synchronous RAM.
// Each accepted sample reads the sample written `delay` samples ago, then writes itself at wr_ptr.
module delay_line_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    output logic          ready,
    input  logic [AW-1:0] delay,
    output logic          out_valid,
    output logic [DW-1:0] sample_out,
    output logic          overrun,
    input  logic          clr_overrun,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_RELOAD = WCW'(RD_LAT - 1);
    localparam logic [AW:0]    FILL_MAX    = {1'b1, {AW{1'b0}}};

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;

    logic [2:0]     state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW:0]    fill_reg;
    logic [DW-1:0]  s_reg;
    logic [AW-1:0]  eff_d_reg;
    logic [AW-1:0]  rd_addr_reg;
    logic [WCW-1:0] wait_cnt_reg;
    logic [DW-1:0]  sample_out_reg;
    logic           overrun_reg;

    logic           accept;
    logic [AW-1:0]  eff_d_next;
    logic           warm_mask;

    assign ready  = (state_reg == ST_IDLE) && rst_n;
    assign accept = ready && sample_valid;

    // A delay input is AW bits wide, so DEPTH-1 is the natural ceiling; only zero needs clamping.
    assign eff_d_next = (delay == '0) ? AW'(1) : delay;

    // Locations older than the number of samples written so far hold no valid audio.
    assign warm_mask = ({1'b0, eff_d_reg} > fill_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_RD;
            ST_RD:   state_next = ST_WAIT;
            ST_WAIT: if (wait_cnt_reg == '0) state_next = ST_CAP;
            ST_CAP:  state_next = ST_WR;
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            fill_reg       <= '0;
            s_reg          <= '0;
            eff_d_reg      <= AW'(1);
            rd_addr_reg    <= '0;
            wait_cnt_reg   <= '0;
            sample_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        s_reg       <= sample_in;
                        eff_d_reg   <= eff_d_next;
                        rd_addr_reg <= wr_ptr_reg - eff_d_next;
                    end
                end
                ST_RD: begin
                    wait_cnt_reg <= WAIT_RELOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt_reg != '0) wait_cnt_reg <= wait_cnt_reg - 1'b1;
                end
                ST_CAP: begin
                    sample_out_reg <= warm_mask ? '0 : ram_dout;
                end
                ST_WR: begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fill_reg != FILL_MAX) fill_reg <= fill_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A new overrun event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun_reg <= 1'b0;
        else if (sample_valid && !ready)
            overrun_reg <= 1'b1;
        else if (clr_overrun)
            overrun_reg <= 1'b0;
    end

    // RAM port is decoded purely from registered state so no input reaches it combinationally.
    always_comb begin
        ram_addr = wr_ptr_reg;
        ram_we   = 1'b0;
        ram_din  = '0;
        case (state_reg)
            ST_RD, ST_WAIT, ST_CAP: ram_addr = rd_addr_reg;
            ST_WR: begin
                ram_addr = wr_ptr_reg;
                ram_we   = 1'b1;
                ram_din  = s_reg;
            end
            default: ;
        endcase
    end

    assign out_valid  = (state_reg == ST_WR);
    assign sample_out = sample_out_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl with a small 16-entry RAM (AW=4, RD_LAT=1).
module tb_delay_line_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample_in;
    logic          ready;
    logic [AW-1:0] delay;
    logic          out_valid;
    logic [DW-1:0] sample_out;
    logic          overrun;
    logic          clr_overrun;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int we_count = 0;
    int ov_count = 0;

    delay_line_ctrl #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
        .ready(ready), .delay(delay), .out_valid(out_valid), .sample_out(sample_out),
        .overrun(overrun), .clr_overrun(clr_overrun), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of registered read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we)    we_count <= we_count + 1;
        if (out_valid) ov_count <= ov_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready", 32'(ready), 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sample_out", 32'(sample_out), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_addr", 32'(ram_addr), 0);
        sample_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("rst_release_ready", 32'(ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic do_accept(input logic [DW-1:0] d, input logic [AW-1:0] dl);
        int n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
        sample_in    = d;
        delay        = dl;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic wait_out(input string tag, input logic [DW-1:0] exp_out,
                            input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_din);
        int n = 0;
        while (!out_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 4);
            check({tag, "_out"}, 32'(sample_out), 32'(exp_out));
            check({tag, "_we"}, 32'(ram_we), 1);
            check({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
            check({tag, "_din"}, 32'(ram_din), 32'(exp_din));
            $display("%s: in=0x%02h out=0x%02h addr=%0d", tag, exp_din, sample_out, ram_addr);
        end
        @(posedge clk); #1;
        check({tag, "_ready_again"}, 32'(ready), 1);
        check({tag, "_out_hold"}, 32'(sample_out), 32'(exp_out));
    endtask

    task automatic send_check(input string tag, input logic [DW-1:0] d, input logic [AW-1:0] dl,
                              input logic [DW-1:0] exp_out, input logic [AW-1:0] exp_addr);
        do_accept(d, dl);
        wait_out(tag, exp_out, exp_addr, d);
    endtask

    initial begin
        logic [DW-1:0] warm_in  [5];
        logic [DW-1:0] warm_exp [5];
        int we_base;
        int ov_base;

        warm_in  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        warm_exp = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hA5;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        delay        = '0;
        clr_overrun  = 1'b0;

        do_reset();

        // Warm-up masking, delay 3
        for (int i = 0; i < 5; i++) begin
            send_check("warm", warm_in[i], 4'd3, warm_exp[i], AW'(i));
            @(posedge clk); #1;
        end

        // Wrap-around with the maximum delay
        do_reset();
        for (int k = 1; k <= 20; k++)
            send_check("wrap", DW'(k), 4'd15, (k <= 15) ? 8'h00 : DW'(k - 15), AW'((k - 1) % 16));

        // delay 0 clamps to 1
        do_reset();
        send_check("clamp", 8'h0A, 4'd0, 8'h00, 4'd0);
        send_check("clamp", 8'h0B, 4'd0, 8'h0A, 4'd1);
        send_check("clamp", 8'h0C, 4'd0, 8'h0B, 4'd2);
        send_check("clamp", 8'h0D, 4'd0, 8'h0C, 4'd3);

        // Overrun: strobes during RD and WAIT are dropped
        we_base = we_count;
        do_accept(8'hE0, 4'd1);
        check("ovr_rd_ready", 32'(ready), 0);
        sample_valid = 1'b1;
        sample_in    = 8'h99;
        @(posedge clk); #1;
        check("ovr_set", 32'(overrun), 1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("ovr_held", 32'(overrun), 1);
        wait_out("ovr", 8'h0D, 4'd4, 8'hE0);
        send_check("ovr_next", 8'hE1, 4'd1, 8'hE0, 4'd5);
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 0);
        do_accept(8'hE2, 4'd1);
        sample_valid = 1'b1;
        clr_overrun  = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        clr_overrun  = 1'b0;
        check("ovr_set_wins", 32'(overrun), 1);
        wait_out("ovr_clr_op", 8'hE1, 4'd6, 8'hE2);
        check("ovr_we_count", 32'(we_count - we_base), 3);
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        check("ovr_clr_alone", 32'(overrun), 0);

        // Reset while waiting on the RAM
        do_accept(8'h77, 4'd1);
        @(posedge clk); #1;
        we_base = we_count;
        ov_base = ov_count;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        check("midrst_we", 32'(ram_we), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("midrst_no_write", 32'(we_count - we_base), 0);
        check("midrst_no_out", 32'(ov_count - ov_base), 0);
        send_check("midrst_next", 8'h88, 4'd3, 8'h00, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequences one single-port synchronous RAM (8-bit data, 16-bit address, `we`/`din`/`dout`) as a circular audio delay line for the pedal datapath.
- Per accepted input sample:
  - reads the sample written `delay` samples earlier and presents it downstream to the processor;
  - then writes the new sample at the write pointer.
- Replaces free-running address pipelining with an explicit read/wait/capture/write schedule, warm-up masking and overrun detection.

Parameters:
- DW, 8, sample/RAM data width.
- AW, 16, RAM address width; DEPTH = 2**AW.
- RD_LAT, 1, RAM read latency in cycles (≥1); number of WAIT cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- sample_valid  in  1  new input sample strobe
- sample_in  in  DW  input sample
- ready  out  1  controller can accept a sample this cycle
- delay  in  AW  requested delay in samples, sampled at acceptance
- out_valid  out  1  one-cycle pulse, sample_out updated
- sample_out  out  DW  delayed sample
- overrun  out  1  sticky: sample_valid seen while not ready
- clr_overrun  in  1  clears overrun
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0.
  - state=IDLE; wr_ptr=0; fill=0; sample_out=0; out_valid=0; overrun=0.
  - ram_we=0, ram_addr=0, ram_din=0; ready=1 once rst_n=1.
- FSM: IDLE → RD → WAIT (RD_LAT cycles) → CAP → WR → IDLE.
- RAM outputs decode from registered state/regs only; no combinational path from any input.
- IDLE:
  - ready=1, ram_we=0.
  - sample_valid=1 accepts the sample: latch sample_in→s_reg.
  - Latch eff_d = clamp(delay, 1, DEPTH-1); delay=0 → 1.
  - rd_addr = (wr_ptr − eff_d) mod DEPTH; go to RD.
- RD: ram_addr=rd_addr, ram_we=0, ready=0.
- WAIT: hold ram_addr=rd_addr for RD_LAT cycles; counter reloads on entry.
- CAP:
  - Sample ram_dout into sample_out at the end of CAP.
  - Warm-up mask: if eff_d > fill, sample_out←0 instead of ram_dout (unwritten location).
- WR:
  - ram_addr=wr_ptr, ram_din=s_reg, ram_we=1 for exactly this one cycle.
  - out_valid=1 this cycle only.
  - At the end of WR: wr_ptr←wr_ptr+1 mod DEPTH (wraps DEPTH-1→0); fill←min(fill+1, DEPTH); go to IDLE.
- Timing with RD_LAT=1:
  - accept at T0; RD T1; WAIT T2; CAP T3; WR/out_valid T4; ready again T5.
  - Throughput: one sample per 4+RD_LAT cycles.
- ready=0 in every state except IDLE.
- Overrun:
  - sample_valid=1 while ready=0 → sample dropped, overrun←1.
  - In-flight operation unaffected.
- clr_overrun=1 → overrun←0. If clr and a new overrun event occur in the same cycle, set wins.
- delay changes while busy are ignored until the next acceptance.
- fill saturates at DEPTH. Once fill ≥ eff_d, masking stops permanently until reset.
- Reset mid-operation:
  - Abort immediately to IDLE with reset values; no partial write.
  - ram_we=0 from the reset cycle on.
- sample_out holds its value between out_valid pulses.

Test Plan:
- Reset:
  - rst_n=0 for 2 cycles with sample_valid=1 → ready stays 0 during reset.
  - ram_we=0, out_valid=0, sample_out=0, overrun=0.
  - After release: ready=1, first write goes to ram_addr=0.
- Warm-up and delay, delay=3:
  - Feed 0x11,0x22,0x33,0x44,0x55 (one per 6 cycles) → out_valid sequence 0x00,0x00,0x00,0x11,0x22.
  - Writes to addresses 0..4.
  - out_valid exactly 4 cycles after each acceptance (RD_LAT=1).
- Wrap-around, AW=4 (DEPTH=16), delay=15:
  - Feed samples 1..20 → sample 16 writes addr 15 and sample 17 writes addr 0.
  - The output on sample 16 equals sample 1.
  - The output on sample 20 equals sample 5.
- Delay clamp:
  - delay=0 → behaves as delay=1: output equals the previous sample (after the first masked 0).
  - AW=4, delay=15 after fill=16 → valid non-zero data.
- Overrun:
  - Assert sample_valid in RD and WAIT cycles → overrun=1, no extra ram_we pulse, wr_ptr advances by 1 only.
  - clr_overrun same cycle as a new overrun → overrun stays 1.
  - clr_overrun alone → overrun=0.
- Reset mid-op:
  - rst_n=0 during WAIT → no ram_we ever asserted for that sample, no out_valid.
  - After release, the next sample writes addr 0 and outputs 0x00 (fill=0).
